// File: rtl/cond_unit_pipe.sv
// Execute-stage condition unit with the NZCV flags register and the D->E, E->M, M->W
// control pipeline registers. Only condition-passing instructions commit side effects.
module cond_unit_pipe #(
    parameter logic [3:0] FLAGS_INIT = 4'b0000
) (
    input  logic       CLK,
    input  logic       Reset,
    input  logic       FlushE,
    input  logic [3:0] CondD,
    input  logic       PCSrcD,
    input  logic       RegWriteD,
    input  logic       MemWriteD,
    input  logic       BranchD,
    input  logic       MemtoRegD,
    input  logic [1:0] ALUControlD,
    input  logic       ALUSrcD,
    input  logic [1:0] FlagWriteD,
    input  logic       NoWriteD,
    input  logic [3:0] ALUFlags,
    output logic [1:0] ALUControlE,
    output logic       ALUSrcE,
    output logic       BranchTakenE,
    output logic       MemWriteM,
    output logic       MemtoRegM,
    output logic       RegWriteM,
    output logic       PCSrcW,
    output logic       RegWriteW,
    output logic       MemtoRegW,
    output logic [3:0] FlagsE
);

    localparam logic [3:0] CondAl = 4'b1110;

    // Execute-stage control register
    logic [3:0] cond_e_q, cond_e_d;
    logic       pcsrc_e_q, pcsrc_e_d;
    logic       regwrite_e_q, regwrite_e_d;
    logic       memwrite_e_q, memwrite_e_d;
    logic       branch_e_q, branch_e_d;
    logic       memtoreg_e_q, memtoreg_e_d;
    logic [1:0] alucontrol_e_q, alucontrol_e_d;
    logic       alusrc_e_q, alusrc_e_d;
    logic [1:0] flagwrite_e_q, flagwrite_e_d;
    logic       nowrite_e_q, nowrite_e_d;

    logic [3:0] flags_q, flags_d;

    // Memory and writeback stage registers
    logic pcsrc_m_q, regwrite_m_q, memwrite_m_q, memtoreg_m_q;
    logic pcsrc_w_q, regwrite_w_q, memtoreg_w_q;

    logic cond_ex;
    logic flag_n, flag_z, flag_c, flag_v;
    logic pcsrc_ge, regwrite_ge, memwrite_ge;

    always_comb begin
        cond_e_d       = CondAl;
        pcsrc_e_d      = 1'b0;
        regwrite_e_d   = 1'b0;
        memwrite_e_d   = 1'b0;
        branch_e_d     = 1'b0;
        memtoreg_e_d   = 1'b0;
        alucontrol_e_d = 2'b00;
        alusrc_e_d     = 1'b0;
        flagwrite_e_d  = 2'b00;
        nowrite_e_d    = 1'b0;
        if (!FlushE) begin
            cond_e_d       = CondD;
            pcsrc_e_d      = PCSrcD;
            regwrite_e_d   = RegWriteD;
            memwrite_e_d   = MemWriteD;
            branch_e_d     = BranchD;
            memtoreg_e_d   = MemtoRegD;
            alucontrol_e_d = ALUControlD;
            alusrc_e_d     = ALUSrcD;
            flagwrite_e_d  = FlagWriteD;
            nowrite_e_d    = NoWriteD;
        end
    end

    assign {flag_n, flag_z, flag_c, flag_v} = flags_q;

    always_comb begin
        cond_ex = 1'b0;
        case (cond_e_q)
            4'b0000: cond_ex = flag_z;
            4'b0001: cond_ex = ~flag_z;
            4'b0010: cond_ex = flag_c;
            4'b0011: cond_ex = ~flag_c;
            4'b0100: cond_ex = flag_n;
            4'b0101: cond_ex = ~flag_n;
            4'b0110: cond_ex = flag_v;
            4'b0111: cond_ex = ~flag_v;
            4'b1000: cond_ex = flag_c & ~flag_z;
            4'b1001: cond_ex = ~flag_c | flag_z;
            4'b1010: cond_ex = (flag_n == flag_v);
            4'b1011: cond_ex = (flag_n != flag_v);
            4'b1100: cond_ex = ~flag_z & (flag_n == flag_v);
            4'b1101: cond_ex = flag_z | (flag_n != flag_v);
            4'b1110: cond_ex = 1'b1;
            default: cond_ex = 1'b0;
        endcase
    end

    assign pcsrc_ge    = pcsrc_e_q & cond_ex;
    assign regwrite_ge = regwrite_e_q & cond_ex & ~nowrite_e_q;
    assign memwrite_ge = memwrite_e_q & cond_ex;

    // Flags are written at the end of the setter's E cycle, so the next E sees them directly.
    always_comb begin
        flags_d = flags_q;
        if (flagwrite_e_q[1] && cond_ex) flags_d[3:2] = ALUFlags[3:2];
        if (flagwrite_e_q[0] && cond_ex) flags_d[1:0] = ALUFlags[1:0];
    end

    always_ff @(posedge CLK) begin
        if (Reset) begin
            cond_e_q       <= CondAl;
            pcsrc_e_q      <= 1'b0;
            regwrite_e_q   <= 1'b0;
            memwrite_e_q   <= 1'b0;
            branch_e_q     <= 1'b0;
            memtoreg_e_q   <= 1'b0;
            alucontrol_e_q <= 2'b00;
            alusrc_e_q     <= 1'b0;
            flagwrite_e_q  <= 2'b00;
            nowrite_e_q    <= 1'b0;
            flags_q        <= FLAGS_INIT;
            pcsrc_m_q      <= 1'b0;
            regwrite_m_q   <= 1'b0;
            memwrite_m_q   <= 1'b0;
            memtoreg_m_q   <= 1'b0;
            pcsrc_w_q      <= 1'b0;
            regwrite_w_q   <= 1'b0;
            memtoreg_w_q   <= 1'b0;
        end else begin
            cond_e_q       <= cond_e_d;
            pcsrc_e_q      <= pcsrc_e_d;
            regwrite_e_q   <= regwrite_e_d;
            memwrite_e_q   <= memwrite_e_d;
            branch_e_q     <= branch_e_d;
            memtoreg_e_q   <= memtoreg_e_d;
            alucontrol_e_q <= alucontrol_e_d;
            alusrc_e_q     <= alusrc_e_d;
            flagwrite_e_q  <= flagwrite_e_d;
            nowrite_e_q    <= nowrite_e_d;
            flags_q        <= flags_d;
            pcsrc_m_q      <= pcsrc_ge;
            regwrite_m_q   <= regwrite_ge;
            memwrite_m_q   <= memwrite_ge;
            memtoreg_m_q   <= memtoreg_e_q;
            pcsrc_w_q      <= pcsrc_m_q;
            regwrite_w_q   <= regwrite_m_q;
            memtoreg_w_q   <= memtoreg_m_q;
        end
    end

    assign ALUControlE  = alucontrol_e_q;
    assign ALUSrcE      = alusrc_e_q;
    assign BranchTakenE = branch_e_q & cond_ex;
    assign MemWriteM    = memwrite_m_q;
    assign MemtoRegM    = memtoreg_m_q;
    assign RegWriteM    = regwrite_m_q;
    assign PCSrcW       = pcsrc_w_q;
    assign RegWriteW    = regwrite_w_q;
    assign MemtoRegW    = memtoreg_w_q;
    assign FlagsE       = flags_q;

endmodule

// File: tb/tb_cond_unit_pipe.sv
// Bench for cond_unit_pipe: directed literal checks followed by random stimulus compared
// every cycle against an instruction-level model of the condition unit and pipeline.
module tb_cond_unit_pipe;

    logic       CLK = 1'b0;
    logic       Reset = 1'b1;
    logic       FlushE = 1'b0;
    logic [3:0] CondD = 4'b1110;
    logic       PCSrcD = 1'b0, RegWriteD = 1'b0, MemWriteD = 1'b0, BranchD = 1'b0;
    logic       MemtoRegD = 1'b0, ALUSrcD = 1'b0, NoWriteD = 1'b0;
    logic [1:0] ALUControlD = 2'b00, FlagWriteD = 2'b00;
    logic [3:0] ALUFlags = 4'b0000;
    logic [1:0] ALUControlE;
    logic       ALUSrcE, BranchTakenE, MemWriteM, MemtoRegM, RegWriteM;
    logic       PCSrcW, RegWriteW, MemtoRegW;
    logic [3:0] FlagsE;

    int checks = 0;
    int errors = 0;

    cond_unit_pipe #(.FLAGS_INIT(4'b0000)) dut (
        .CLK(CLK), .Reset(Reset), .FlushE(FlushE), .CondD(CondD), .PCSrcD(PCSrcD),
        .RegWriteD(RegWriteD), .MemWriteD(MemWriteD), .BranchD(BranchD),
        .MemtoRegD(MemtoRegD), .ALUControlD(ALUControlD), .ALUSrcD(ALUSrcD),
        .FlagWriteD(FlagWriteD), .NoWriteD(NoWriteD), .ALUFlags(ALUFlags),
        .ALUControlE(ALUControlE), .ALUSrcE(ALUSrcE), .BranchTakenE(BranchTakenE),
        .MemWriteM(MemWriteM), .MemtoRegM(MemtoRegM), .RegWriteM(RegWriteM),
        .PCSrcW(PCSrcW), .RegWriteW(RegWriteW), .MemtoRegW(MemtoRegW), .FlagsE(FlagsE)
    );

    always #5 CLK = ~CLK;

    task automatic check(input string name, input logic [3:0] act, input logic [3:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    // Condition passes, stated as base test on cond[3:1] with cond[0] inverting (NV never passes)
    function automatic logic passes(input logic [3:0] c, input logic [3:0] f);
        logic n, z, cf, v, r;
        {n, z, cf, v} = f;
        case (c[3:1])
            3'd0: r = z;
            3'd1: r = cf;
            3'd2: r = n;
            3'd3: r = v;
            3'd4: r = cf && !z;
            3'd5: r = (n == v);
            3'd6: r = !z && (n == v);
            default: r = 1'b1;
        endcase
        if (c[0]) r = (c == 4'b1111) ? 1'b0 : !r;
        return r;
    endfunction

    typedef struct packed {
        logic [3:0] cond;
        logic pcsrc, regwrite, memwrite, branch, memtoreg;
        logic [1:0] aluc;
        logic alusrc;
        logic [1:0] fw;
        logic nowrite;
    } instr_t;

    // Committed effects of an instruction as it leaves E
    typedef struct packed {
        logic pcsrc, regwrite, memwrite, memtoreg;
    } effect_t;

    localparam instr_t Bubble = '{cond: 4'b1110, default: '0};

    instr_t    mdl_e;
    logic [3:0] mdl_flags;
    effect_t   hist [$];    // hist[0] = stage M, hist[1] = stage W
    bit        mdl_valid = 1'b0;

    always @(posedge CLK) begin : model
        instr_t  nxt;
        effect_t eff;
        logic    ok;
        logic [3:0] nf;
        nxt = '{cond: CondD, pcsrc: PCSrcD, regwrite: RegWriteD, memwrite: MemWriteD,
                branch: BranchD, memtoreg: MemtoRegD, aluc: ALUControlD, alusrc: ALUSrcD,
                fw: FlagWriteD, nowrite: NoWriteD};
        if (Reset) begin
            mdl_e     <= Bubble;
            mdl_flags <= 4'b0000;
            hist = {};
            hist.push_back('0);
            hist.push_back('0);
            mdl_valid <= 1'b1;
        end else if (mdl_valid) begin
            ok = passes(mdl_e.cond, mdl_flags);
            eff.pcsrc    = mdl_e.pcsrc && ok;
            eff.regwrite = mdl_e.regwrite && ok && !mdl_e.nowrite;
            eff.memwrite = mdl_e.memwrite && ok;
            eff.memtoreg = mdl_e.memtoreg;
            hist.push_front(eff);
            hist.pop_back();
            nf = mdl_flags;
            if (ok && mdl_e.fw[1]) nf[3:2] = ALUFlags[3:2];
            if (ok && mdl_e.fw[0]) nf[1:0] = ALUFlags[1:0];
            mdl_flags <= nf;
            mdl_e     <= FlushE ? Bubble : nxt;
        end
    end

    always @(negedge CLK) begin : compare
        if (mdl_valid) begin
            check("ALUControlE", {2'b00, ALUControlE}, {2'b00, mdl_e.aluc});
            check("ALUSrcE", {3'b000, ALUSrcE}, {3'b000, mdl_e.alusrc});
            check("BranchTakenE", {3'b000, BranchTakenE},
                  {3'b000, mdl_e.branch && passes(mdl_e.cond, mdl_flags)});
            check("FlagsE", FlagsE, mdl_flags);
            check("MemWriteM", {3'b000, MemWriteM}, {3'b000, hist[0].memwrite});
            check("MemtoRegM", {3'b000, MemtoRegM}, {3'b000, hist[0].memtoreg});
            check("RegWriteM", {3'b000, RegWriteM}, {3'b000, hist[0].regwrite});
            check("PCSrcW", {3'b000, PCSrcW}, {3'b000, hist[1].pcsrc});
            check("RegWriteW", {3'b000, RegWriteW}, {3'b000, hist[1].regwrite});
            check("MemtoRegW", {3'b000, MemtoRegW}, {3'b000, hist[1].memtoreg});
        end
    end

    task automatic step();
        @(posedge CLK);
        #2;
    endtask

    task automatic drive(input logic [3:0] c, input logic regw, input logic memw,
                         input logic br, input logic [1:0] fw, input logic nw);
        CondD = c; RegWriteD = regw; MemWriteD = memw; BranchD = br;
        FlagWriteD = fw; NoWriteD = nw;
        PCSrcD = 1'b0; MemtoRegD = 1'b0; ALUControlD = 2'b00; ALUSrcD = 1'b0;
    endtask

    initial begin
        // Reset state
        drive(4'b1110, 0, 0, 0, 2'b00, 0);
        step();
        check("rst_FlagsE", FlagsE, 4'b0000);
        check("rst_RegWriteM", {3'b0, RegWriteM}, 4'd0);
        check("rst_RegWriteW", {3'b0, RegWriteW}, 4'd0);
        check("rst_BranchTakenE", {3'b0, BranchTakenE}, 4'd0);
        Reset = 1'b0;

        // CMP sets Z, then EQ commits and NE does not
        drive(4'b1110, 1, 0, 0, 2'b11, 1);
        step();
        ALUFlags = 4'b0100;
        drive(4'b0000, 1, 0, 0, 2'b00, 0);
        step();
        check("cmp_FlagsE", FlagsE, 4'b0100);
        check("cmp_RegWriteM", {3'b0, RegWriteM}, 4'd0);
        drive(4'b0001, 1, 0, 0, 2'b00, 0);
        step();
        check("eq_RegWriteM", {3'b0, RegWriteM}, 4'd1);
        drive(4'b1110, 0, 0, 0, 2'b00, 0);
        step();
        check("ne_RegWriteM", {3'b0, RegWriteM}, 4'd0);
        check("eq_RegWriteW", {3'b0, RegWriteW}, 4'd1);
        step();
        check("ne_RegWriteW", {3'b0, RegWriteW}, 4'd0);

        // GE branch with N==V taken, N!=V not taken
        drive(4'b1110, 0, 0, 0, 2'b11, 1);
        step();
        ALUFlags = 4'b1001;
        drive(4'b1010, 0, 0, 1, 2'b00, 0);
        step();
        check("ge_FlagsE", FlagsE, 4'b1001);
        check("ge_taken", {3'b0, BranchTakenE}, 4'd1);
        drive(4'b1110, 0, 0, 0, 2'b11, 1);
        step();
        ALUFlags = 4'b1000;
        drive(4'b1010, 0, 0, 1, 2'b00, 0);
        step();
        check("lt_FlagsE", FlagsE, 4'b1000);
        check("ge_not_taken", {3'b0, BranchTakenE}, 4'd0);

        // Failing flag-setter leaves flags alone
        drive(4'b1110, 0, 0, 0, 2'b11, 1);
        step();
        ALUFlags = 4'b0000;
        drive(4'b0000, 0, 0, 0, 2'b11, 1);
        step();
        check("clr_FlagsE", FlagsE, 4'b0000);
        ALUFlags = 4'b1111;
        drive(4'b1110, 0, 0, 0, 2'b00, 0);
        step();
        check("fail_FlagsE", FlagsE, 4'b0000);

        // Flushed store never reaches M; an unflushed one does
        drive(4'b1110, 0, 1, 0, 2'b00, 0);
        FlushE = 1'b1;
        step();
        FlushE = 1'b0;
        drive(4'b1110, 0, 0, 0, 2'b00, 0);
        step();
        check("flush_MemWriteM", {3'b0, MemWriteM}, 4'd0);
        check("flush_FlagsE", FlagsE, 4'b0000);
        drive(4'b1110, 0, 1, 0, 2'b00, 0);
        step();
        drive(4'b1110, 0, 0, 0, 2'b00, 0);
        step();
        check("store_MemWriteM", {3'b0, MemWriteM}, 4'd1);

        // Reset mid-stream of register writes
        drive(4'b1110, 1, 0, 0, 2'b00, 0);
        repeat (3) step();
        check("pre_rst_RegWriteW", {3'b0, RegWriteW}, 4'd1);
        Reset = 1'b1;
        FlushE = 1'b1;
        step();
        Reset = 1'b0;
        FlushE = 1'b0;
        check("mid_rst_RegWriteM", {3'b0, RegWriteM}, 4'd0);
        check("mid_rst_RegWriteW", {3'b0, RegWriteW}, 4'd0);
        check("mid_rst_FlagsE", FlagsE, 4'b0000);
        step();
        check("post_rst_RegWriteM", {3'b0, RegWriteM}, 4'd0);
        check("post_rst_RegWriteW", {3'b0, RegWriteW}, 4'd0);
        step();
        check("resume_RegWriteM", {3'b0, RegWriteM}, 4'd1);

        // Random traffic against the model
        repeat (3000) begin
            CondD       = 4'($urandom);
            PCSrcD      = 1'($urandom);
            RegWriteD   = 1'($urandom);
            MemWriteD   = 1'($urandom);
            BranchD     = 1'($urandom);
            MemtoRegD   = 1'($urandom);
            ALUControlD = 2'($urandom);
            ALUSrcD     = 1'($urandom);
            FlagWriteD  = 2'($urandom);
            NoWriteD    = ($urandom_range(0, 3) == 0);
            ALUFlags    = 4'($urandom);
            FlushE      = ($urandom_range(0, 7) == 0);
            Reset       = ($urandom_range(0, 63) == 0);
            step();
        end
        Reset = 1'b0;
        FlushE = 1'b0;
        step();

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
